// File: rtl/c0_pkg.sv
// c0_pkg: shared encodings for the c0 control unit.
// Holds instruction class codes, MS (memory source) codes, the HALT opcode,
// the fetch timeout limit and the controller FSM state enum.
package c0_pkg;

   // Instruction class, B0[7:6]
   localparam logic [1:0] CLS_ALU     = 2'b00;
   localparam logic [1:0] CLS_MOV_REG = 2'b01;
   localparam logic [1:0] CLS_MOV_IMM = 2'b10;
   localparam logic [1:0] CLS_BRANCH  = 2'b11;

   // Memory source select driven to the core
   localparam logic [1:0] MS_ALU = 2'b00;
   localparam logic [1:0] MS_REG = 2'b01;
   localparam logic [1:0] MS_IMM = 2'b10;

   // Branch with this opcode stops the controller
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Fetch cycles without PM_ACK before faulting (timeout build only)
   localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

   // F0..F2 are encoded 0..2 so state[1:0] doubles as the fetch byte index
   typedef enum logic [2:0] {
      ST_F0   = 3'd0,
      ST_F1   = 3'd1,
      ST_F2   = 3'd2,
      ST_EXEC = 3'd3,
      ST_HALT = 3'd4,
      ST_FLT  = 3'd5
   } state_t;

endpackage

// File: rtl/c0_cu_decode.sv
// c0_cu_decode: purely combinational decode of the 24-bit instruction
// register into core control fields and instruction strobes.
// IR layout: [7:0]=B0 {CLS,RS,AR}, [15:8]=B1 {OP,IRSB,BS}, [23:16]=IMM.
module c0_cu_decode
   import c0_pkg::*;
(
   input  logic [23:0] ir,
   output logic        mem_inst,
   output logic        alu_inst,
   output logic        jmp_inst,
   output logic        halt,
   output logic [1:0]  ms,
   output logic        irs,
   output logic [2:0]  rs,
   output logic [2:0]  ar,
   output logic [2:0]  bs,
   output logic [3:0]  op,
   output logic [7:0]  imm
);

   logic [1:0] cls;
   assign cls = ir[7:6];

   // Field extraction is fixed; class only selects strobes, MS and IRS
   always_comb begin
      mem_inst = 1'b0;
      alu_inst = 1'b0;
      jmp_inst = 1'b0;
      halt     = 1'b0;
      ms       = MS_ALU;
      irs      = 1'b0;
      rs       = ir[5:3];
      ar       = ir[2:0];
      op       = ir[15:12];
      bs       = ir[10:8];
      imm      = ir[23:16];
      case (cls)
         CLS_ALU: begin
            mem_inst = 1'b1;
            alu_inst = 1'b1;
            ms       = MS_ALU;
            irs      = ir[11];
         end
         CLS_MOV_REG: begin
            mem_inst = 1'b1;
            ms       = MS_REG;
            irs      = 1'b0;
         end
         CLS_MOV_IMM: begin
            mem_inst = 1'b1;
            ms       = MS_IMM;
            irs      = 1'b1;
         end
         default: begin
            // Branch: OP carries the branch condition; OP_HALT stops instead
            ms = MS_ALU;
            if (ir[15:12] == OP_HALT) halt = 1'b1;
            else                      jmp_inst = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/c0_ctrl_unit.sv
// c0_ctrl_unit: fetches 3-byte instructions from program memory at
// {PC, byte}, decodes them and presents one EXEC cycle of control to the core.
// Optional feature: define C0_CU_TIMEOUT_EN to fault after TIMEOUT_LIMIT
// fetch cycles without PM_ACK.
// Handshake: a byte is taken on a rising edge where PM_REQ and PM_ACK are
// both 1; PM_ACK may be high in the same cycle PM_REQ rises; PM_ACK with
// PM_REQ low is ignored and PM_DATA is not sampled.
module c0_ctrl_unit
   import c0_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] PC,
   output logic [9:0] PM_ADDR,
   output logic       PM_REQ,
   input  logic       PM_ACK,
   input  logic [7:0] PM_DATA,
   output logic       MEM_INST,
   output logic       ALU_INST,
   output logic       JMP_INST,
   output logic [1:0] MS,
   output logic       IRS,
   output logic [2:0] RS,
   output logic [2:0] AR,
   output logic [2:0] BS,
   output logic [3:0] OP,
   output logic [7:0] IMM,
   output logic       EXEC_EN,
   output logic       HALTED,
   output logic       FAULT,
   output logic [2:0] STATE_DBG
);

   state_t      state, state_next;
   logic [23:0] ir_q;
   logic [23:0] ir_fetch;
   logic        run_q;     // low during reset so PM_REQ is 0 until the first edge
   logic        fetch;
   logic        accept;
   logic [1:0]  byte_idx;

   logic       d_mem, d_alu, d_jmp, d_halt, d_irs;
   logic [1:0] d_ms;
   logic [2:0] d_rs, d_ar, d_bs;
   logic [3:0] d_op;
   logic [7:0] d_imm;

`ifdef C0_CU_TIMEOUT_EN
   logic [3:0] tmo_cnt;
`endif

   assign byte_idx  = state[1:0];
   assign fetch     = run_q && (state == ST_F0 || state == ST_F1 || state == ST_F2);
   assign accept    = fetch && PM_ACK;
   assign PM_REQ    = fetch;
   assign PM_ADDR   = fetch ? {PC, byte_idx} : 10'd0;
   assign EXEC_EN   = (state == ST_EXEC);
   assign HALTED    = (state == ST_HALT);
   assign STATE_DBG = state;
`ifdef C0_CU_TIMEOUT_EN
   assign FAULT     = (state == ST_FLT);
`else
   assign FAULT     = 1'b0;
`endif

   // IR as it will be after this cycle's accepted byte, so decode is ready at F2
   always_comb begin
      ir_fetch = ir_q;
      if (accept) begin
         case (byte_idx)
            2'd0:    ir_fetch[7:0]   = PM_DATA;
            2'd1:    ir_fetch[15:8]  = PM_DATA;
            default: ir_fetch[23:16] = PM_DATA;
         endcase
      end
   end

   c0_cu_decode u_decode (
      .ir       (ir_fetch),
      .mem_inst (d_mem),
      .alu_inst (d_alu),
      .jmp_inst (d_jmp),
      .halt     (d_halt),
      .ms       (d_ms),
      .irs      (d_irs),
      .rs       (d_rs),
      .ar       (d_ar),
      .bs       (d_bs),
      .op       (d_op),
      .imm      (d_imm)
   );

   // Next-state: byte-by-byte fetch, one EXEC cycle, sticky HALT/FLT
   always_comb begin
      state_next = state;
      case (state)
         ST_F0:   if (accept) state_next = ST_F1;
         ST_F1:   if (accept) state_next = ST_F2;
         ST_F2:   if (accept) state_next = d_halt ? ST_HALT : ST_EXEC;
         ST_EXEC: state_next = ST_F0;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_FLT;
      endcase
`ifdef C0_CU_TIMEOUT_EN
      if (fetch && !PM_ACK && tmo_cnt == TIMEOUT_LIMIT - 4'd1) state_next = ST_FLT;
`endif
   end

   // State, IR and registered control outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_F0;
         run_q    <= 1'b0;
         ir_q     <= 24'd0;
         MEM_INST <= 1'b0;
         ALU_INST <= 1'b0;
         JMP_INST <= 1'b0;
         MS       <= 2'd0;
         IRS      <= 1'b0;
         RS       <= 3'd0;
         AR       <= 3'd0;
         BS       <= 3'd0;
         OP       <= 4'd0;
         IMM      <= 8'd0;
      end else begin
         state <= state_next;
         run_q <= 1'b1;
         if (accept) ir_q <= ir_fetch;
         if (accept && state == ST_F2) begin
            // Strobes are 0 from decode for HALT, so HALT gets no strobe
            MEM_INST <= d_mem;
            ALU_INST <= d_alu;
            JMP_INST <= d_jmp;
            MS       <= d_ms;
            IRS      <= d_irs;
            RS       <= d_rs;
            AR       <= d_ar;
            BS       <= d_bs;
            OP       <= d_op;
            IMM      <= d_imm;
         end
         if (state == ST_EXEC) begin
            MEM_INST <= 1'b0;
            ALU_INST <= 1'b0;
            JMP_INST <= 1'b0;
         end
      end
   end

`ifdef C0_CU_TIMEOUT_EN
   // Counts fetch cycles without an accepted byte; cleared on each accept
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      tmo_cnt <= 4'd0;
      else if (accept) tmo_cnt <= 4'd0;
      else if (fetch)  tmo_cnt <= tmo_cnt + 4'd1;
   end
`endif

endmodule

// File: tb/tb_c0_ctrl_unit.sv
// tb_c0_ctrl_unit: directed bench for c0_ctrl_unit with a program-memory
// responder that can delay the byte-1 acknowledge.
module tb_c0_ctrl_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] pc;
   logic [9:0] pm_addr;
   logic       pm_req;
   logic       pm_ack;
   logic [7:0] pm_data;
   logic       mem_inst, alu_inst, jmp_inst;
   logic [1:0] ms;
   logic       irs;
   logic [2:0] rs, ar, bs;
   logic [3:0] op;
   logic [7:0] imm;
   logic       exec_en, halted, fault;
   logic [2:0] state_dbg;

   logic [7:0] mem [0:1023];
   logic       ack_en;
   logic       force_ack;
   int         ack_delay;
   int         wait_cnt;
   int         n_checks;
   int         n_pass;
   int         n;
   int         held;

   c0_ctrl_unit dut (
      .CLK(clk), .RST_N(rst_n), .PC(pc), .PM_ADDR(pm_addr), .PM_REQ(pm_req),
      .PM_ACK(pm_ack), .PM_DATA(pm_data), .MEM_INST(mem_inst),
      .ALU_INST(alu_inst), .JMP_INST(jmp_inst), .MS(ms), .IRS(irs), .RS(rs),
      .AR(ar), .BS(bs), .OP(op), .IMM(imm), .EXEC_EN(exec_en),
      .HALTED(halted), .FAULT(fault), .STATE_DBG(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program-memory responder, driven away from the active edge
   always @(negedge clk) begin
      if (force_ack) begin
         pm_ack = 1'b1;
      end else if (ack_en && pm_req) begin
         if (pm_addr[1:0] == 2'd1 && wait_cnt < ack_delay) begin
            pm_ack   = 1'b0;
            wait_cnt = wait_cnt + 1;
         end else begin
            pm_ack   = 1'b1;
            pm_data  = mem[pm_addr];
            wait_cnt = 0;
         end
      end else begin
         pm_ack   = 1'b0;
         wait_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Advance until EXEC_EN; n counts cycles with cycle 1 = first F0 cycle
   task automatic wait_exec(input int start, output int cyc);
      cyc = start;
      while (!exec_en && cyc < 60) begin
         step();
         cyc = cyc + 1;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b1;
      pc        = 8'd0;
      pm_ack    = 1'b0;
      pm_data   = 8'd0;
      ack_en    = 1'b1;
      force_ack = 1'b0;
      ack_delay = 0;
      wait_cnt  = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      // PC 0: MOV imm RS=0 IMM=5
      mem[0]  = 8'b10_000_000; mem[1]  = 8'h00;        mem[2]  = 8'd5;
      // PC 1: ALU, BS=1, OP=0
      mem[4]  = 8'b00_000_000; mem[5]  = 8'b0000_0_001; mem[6]  = 8'hAA;
      // PC 2: branch RS=6 OP=8 IMM=63
      mem[8]  = 8'b11_110_000; mem[9]  = 8'b1000_0000; mem[10] = 8'd63;
      // PC 3: MOV reg RS=3 AR=5, IRSB=1 (must not reach IRS), BS=2 OP=2
      mem[12] = 8'b01_011_101; mem[13] = 8'b0010_1_010; mem[14] = 8'd7;
      // PC 5: MOV imm RS=1 AR=2 IMM=9
      mem[20] = 8'b10_001_010; mem[21] = 8'h00;        mem[22] = 8'd9;
      // PC 6: HALT
      mem[24] = 8'b11_000_000; mem[25] = 8'b1111_0000; mem[26] = 8'd0;

      // Reset state
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pm_req", pm_req, 0);
      check("rst_pm_addr", pm_addr, 0);
      check("rst_strobes", {mem_inst, alu_inst, jmp_inst}, 0);
      check("rst_flags", {exec_en, halted, fault}, 0);
      check("rst_state", state_dbg, 0);
      release_reset();
      check("f0_pm_req", pm_req, 1);
      check("f0_pm_addr", pm_addr, 10'd0);

      // MOV imm, immediate ack: EXEC in cycle 4
      wait_exec(1, n);
      check("movi_exec_cycle", n, 4);
      check("movi_strobes", {mem_inst, alu_inst, jmp_inst}, 3'b100);
      check("movi_ms_irs", {ms, irs}, {2'b10, 1'b1});
      check("movi_rs", rs, 0);
      check("movi_imm", imm, 5);
      pc = 8'd1;
      step();
      check("movi_post_strobes", {mem_inst, alu_inst, jmp_inst, exec_en}, 0);
      check("alu_f0_addr", pm_addr, {8'd1, 2'b00});

      // ALU
      wait_exec(1, n);
      check("alu_exec_cycle", n, 4);
      check("alu_strobes", {mem_inst, alu_inst, jmp_inst}, 3'b110);
      check("alu_ms_irs", {ms, irs}, 3'b000);
      check("alu_bs_op", {bs, op}, {3'd1, 4'd0});
      pc = 8'd2;
      step();
      check("alu_post_strobes", {mem_inst, alu_inst, jmp_inst}, 0);
      check("alu_hold_bs", bs, 1);

      // Branch
      wait_exec(1, n);
      check("jmp_exec_cycle", n, 4);
      check("jmp_strobes", {mem_inst, alu_inst, jmp_inst}, 3'b001);
      check("jmp_op_imm", {op, imm}, {4'd8, 8'd63});
      check("jmp_ms_rs", {ms, rs}, {2'b00, 3'd6});
      pc = 8'd3;
      ack_delay = 3;
      step();
      check("jmp_next_addr", pm_addr, {8'd3, 2'b00});

      // MOV reg with byte-1 ack delayed 3 cycles: EXEC in cycle 7
      for (int c = 2; c <= 4; c++) begin
         step();
         check("dly_req_addr", {pm_req, pm_addr}, {1'b1, 8'd3, 2'b01});
      end
      wait_exec(4, n);
      check("dly_exec_cycle", n, 7);
      check("movr_strobes", {mem_inst, alu_inst, jmp_inst}, 3'b100);
      check("movr_ms_irs", {ms, irs}, {2'b01, 1'b0});
      check("movr_fields", {rs, ar, bs, op, imm}, {3'd3, 3'd5, 3'd2, 4'd2, 8'd7});

      // Reset pulse mid-F1 clears registered fields and restarts at {PC,00}
      pc = 8'd5;
      ack_delay = 5;
      step();
      step();
      check("f1_addr", pm_addr, {8'd5, 2'b01});
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req_addr", {pm_req, pm_addr}, 0);
      check("midrst_fields", {ms, irs, rs, ar, bs, op, imm}, 0);
      check("midrst_state", state_dbg, 0);
      ack_delay = 0;
      release_reset();
      check("restart_addr", {pm_req, pm_addr}, {1'b1, 8'd5, 2'b00});
      wait_exec(1, n);
      check("restart_exec_cycle", n, 4);
      check("restart_imm_ms", {imm, ms}, {8'd9, 2'b10});

      // HALT: no strobe, sticky, ignores PM_ACK while PM_REQ is low
      pc = 8'd6;
      step();
      n = 1;
      while (!halted && n < 60) begin
         step();
         n = n + 1;
      end
      check("halt_cycle", n, 4);
      force_ack = 1'b1;
      held = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (halted && !pm_req && !mem_inst && !alu_inst && !jmp_inst && !exec_en)
            held = held + 1;
      end
      check("halt_held_cycles", held, 20);

      // Missing acknowledge
      rst_n = 1'b0;
      #1;
      check("halt_rst", {halted, pm_req}, 0);
      force_ack = 1'b0;
      ack_en = 1'b0;
      release_reset();
`ifdef C0_CU_TIMEOUT_EN
      repeat (14) step();
      check("tmo_not_yet", fault, 0);
      step();
      check("tmo_fault", {fault, pm_req}, 2'b10);
`else
      repeat (100) step();
      check("noack_req_held", {pm_req, pm_addr}, {1'b1, 8'd6, 2'b00});
      check("noack_no_fault", fault, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/c0_ctrl_unit.md
C0_CTRL_UNIT -- requirements
Module: c0_ctrl_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: RST_N  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: PC  in  8  current instruction pointer from core (core Addr output).
REQ-004 SHALL have ports: PM_ADDR  out  10  program-memory byte address = {PC, byte index[1:0]}.
REQ-005 SHALL have ports: PM_REQ  out  1 (request); PM_ACK  in  1 (data valid); PM_DATA  in  8 (instruction byte).
REQ-006 SHALL have ports: MEM_INST, ALU_INST, JMP_INST  out  1 each  core instruction strobes.
REQ-007 SHALL have ports: MS  out  2; IRS  out  1; RS, AR, BS  out  3 each; OP  out  4; IMM  out  8  core control fields.
REQ-008 SHALL have ports: EXEC_EN  out  1 (execute cycle); HALTED  out  1; FAULT  out  1.

Function
REQ-009 Instruction SHALL be 3 bytes at PC*4+0..2: B0 = {CLS[1:0], RS[2:0], AR[2:0]}, B1 = {OP[3:0], IRSB, BS[2:0]}, B2 = IMM.
REQ-010 FSM states SHALL be F0, F1, F2, EXEC, HALT, FLT; reset state is F0.
REQ-011 In Fn, PM_REQ=1 and PM_ADDR={PC,n}; on PM_ACK=1 latch PM_DATA into IR byte n and advance (F0->F1->F2->EXEC); PM_ACK same cycle as PM_REQ rise is legal (1-cycle byte fetch).
REQ-012 PM_ACK while PM_REQ=0 SHALL be ignored; PM_DATA SHALL be sampled only when PM_REQ and PM_ACK both high.
REQ-013 EXEC SHALL last exactly one cycle with EXEC_EN=1 and one strobe set, then go to F0 using the PC value present in F0; minimum instruction latency 4 cycles.
REQ-014 Decode CLS=00 (ALU): MEM_INST=1, ALU_INST=1, MS=00, IRS=IRSB.
REQ-015 Decode CLS=01 (MOV reg): MEM_INST=1, MS=01, IRS=0; CLS=10 (MOV imm): MEM_INST=1, MS=10, IRS=1.
REQ-016 Decode CLS=11 (branch): JMP_INST=1, MEM_INST=0, MS=00, OP passes branch condition; CLS=11 with OP=4'b1111 SHALL instead enter HALT with no strobe.
REQ-017 MEM_INST, ALU_INST, JMP_INST SHALL be 0 in every state except EXEC; RS/AR/BS/OP/IMM/MS/IRS SHALL be registered and hold last decoded value.
REQ-018 HALT SHALL assert HALTED=1, PM_REQ=0, and stay until reset.

Reset
REQ-019 RST_N low SHALL immediately force state F0 and all outputs, IR, and timeout counter to 0, including mid-fetch or mid-EXEC.
REQ-020 After RST_N rises, PM_REQ SHALL assert on the first following clock edge's state (F0).

Configuration
REQ-021 With C0_CU_TIMEOUT_EN defined: 4-bit counter counts cycles in Fn without PM_ACK; at 15 go to FLT (FAULT=1, PM_REQ=0, strobes 0) until reset; counter clears on each accepted byte.
REQ-022 Without C0_CU_TIMEOUT_EN: Fn waits indefinitely; FAULT tied 0; FLT unreachable.

Structure
REQ-023 Package c0_pkg SHALL hold CLS encodings, MS encodings, HALT opcode 4'b1111, FSM state enum, timeout limit 15.
REQ-024 Combinational decode SHALL be sub-module c0_cu_decode (IR in, control fields out); FSM, IR and output registers stay in c0_ctrl_unit.

Verification
REQ-025 PC=0, memory bytes {8'b10_000_000, 8'h00, 8'd5}, ACK immediate -> EXEC in cycle 4: MEM_INST=1, MS=10, IRS=1, RS=0, IMM=5.
REQ-026 Bytes {8'b00_000_000, 8'b0000_0_001, x} -> ALU_INST=1, MEM_INST=1, MS=00, IRS=0, BS=1, OP=0; strobes 0 in following cycle.
REQ-027 Bytes {8'b11_110_000, 8'b1000_0000, 8'd63} -> JMP_INST=1, MEM_INST=0, OP=8, IMM=63; next F0 uses updated PC, PM_ADDR={PC,2'b00}.
REQ-028 ACK delayed 3 cycles on byte 1 -> PM_REQ held, PM_ADDR stable ={PC,01}, EXEC at cycle 7.
REQ-029 Branch OP=1111 -> HALTED=1, PM_REQ=0 for 20 cycles; RST_N pulse mid-F1 -> outputs 0, fetch restarts at {PC,00}.
REQ-030 With C0_CU_TIMEOUT_EN, no ACK -> FAULT=1 after 15 cycles in F0; without macro, PM_REQ still 1 after 100 cycles.
